arb16_sched: RTL and testbench
==============================

# arb16_sched

Round-robin scheduler that shares the 16:1 single-bit multiplexer among 16 requesters. It arbitrates level-sensitive requests, holds a grant until the owner releases it, and drives the registered 4-bit select that steers the multiplexer. It sits directly in front of the mux select input; requester `i` owns data bit `in[i]` while granted.

## Interface
- `N_REQ`, 16: number of requesters; fixed at 16 to match the 4-bit select.
- `HOLD_MAX`, 255: maximum grant length in cycles; used only when the timeout feature is compiled in; legal range 1..255.

- `clk`  in  1  rising-edge clock, the only clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req`  in  16  level requests; `req[i]` stays high for as long as requester `i` wants the mux.
- `gnt`  out  16  one-hot grant, registered; all zero when no owner.
- `sel`  out  4  registered mux select, equal to the index of the set `gnt` bit; holds its last value when idle.
- `valid`  out  1  high while `gnt` is nonzero.
- `timeout`  out  1  one-cycle pulse when a grant is forcibly revoked; constant 0 without `ARB16_TIMEOUT_EN`.

## Operation
- State register has two states, IDLE and GRANT, plus a 4-bit round-robin pointer `ptr`. `ptr` is the highest-priority index.
- Reset: `rst_n`=0 at an edge forces IDLE, `ptr`=0, `gnt`=0, `sel`=0, `valid`=0 and `timeout`=0. A reset mid-grant drops the grant at that edge.
- IDLE:
  - If `req` is nonzero, the winner is the first set bit scanning `ptr`, `ptr+1`, ..., wrapping 15→0.
  - At the edge, `gnt`=onehot(winner), `sel`=winner, `valid`=1, and the state moves to GRANT.
- GRANT:
  - While `req[sel]`=1, `gnt`, `sel` and `valid` hold and requests from others are ignored.
  - When `req[sel]`=0 at an edge: `gnt`=0, `valid`=0, `ptr`=`sel`+1 (mod 16, so 15→0), and the state moves to IDLE.
- Between consecutive grants there is always one IDLE cycle with `valid`=0. This guarantees no select change while a grant is asserted.
- A request that drops in IDLE before being sampled is never granted.
- Fairness: with all 16 requesting continuously and each holding for one cycle, grants follow 0,1,...,15,0 in order.
- A lone requester that re-requests is granted again after its one IDLE gap.

## Timing
- Request to grant: `req` sampled in IDLE at edge k gives `gnt`/`sel`/`valid` high after edge k. Latency is 1 cycle.
- Release to next grant: `req[sel]` low at edge k clears the grant after edge k. The next grant appears after edge k+1.
- The mux output `in[sel]` belongs to the owner for every cycle `valid`=1.
- All outputs come straight from flops; there is no combinational path from `req` to any output.

## Configuration
- `ARB16_TIMEOUT_EN` defined:
  - An 8-bit hold counter clears on entry to GRANT and increments every GRANT cycle.
  - If `req[sel]` is still 1 when the count equals `HOLD_MAX`-1, the next edge performs a normal release and `timeout` pulses high for exactly that one cycle. The release advances `ptr`, which puts the revoked requester behind all others.
  - A voluntary release on the same edge takes precedence, and `timeout` stays 0.
- `ARB16_TIMEOUT_EN` undefined: no counter is built, `timeout` is tied to 0, and a grant lasts indefinitely.

## Structure
- Package `arb16_pkg`:
  - `N_REQ`=16 and `SEL_W`=4.
  - State enum `arb16_state_t` with values IDLE and GRANT.
  - Default `HOLD_MAX`.
- Sub-module `rr_pick16`: purely combinational rotate-priority encoder. Inputs are `req[15:0]` and `ptr[3:0]`; outputs are `any` and `idx[3:0]`. The top level holds all state.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `req`=16'hFFFF → `gnt`=0, `sel`=0, `valid`=0 during reset; first grant goes to 0, one cycle after `rst_n` rises.
- Single requester: `req`=16'h0020 for 5 cycles, then 0 → `gnt`=16'h0020 and `sel`=5 for cycles 1–5 after assertion, clear one cycle after the drop, then `ptr`=6.
- Round robin with wrap: all 16 requesting, each dropping the cycle after its grant → grant order 0..15, 0. `valid` toggles 1,0 with an IDLE gap each time. After 15 wins, `ptr` wraps to 0.
- Priority after wrap: `ptr`=14 with `req`=16'h8003 → order 15, 0, 1.
- Reset mid-grant: requester 9 granted, `rst_n`=0 for one edge → `gnt`=0 at that edge; re-arbitration starts from `ptr`=0.
- Timeout (macro on, `HOLD_MAX`=4): requester 3 holds `req` high and requester 4 also requests → 4 cycles of grant to 3, then `timeout`=1 for one cycle; after the gap, `gnt`=16'h0010.

Source files
------------

// File: rtl/arb16_pkg.sv
// Shared constants and types for the arb16_sched round-robin mux scheduler.
// Holds requester count, select width, default hold limit and FSM states.
package arb16_pkg;

    localparam int N_REQ        = 16;
    localparam int SEL_W        = 4;
    localparam int HOLD_MAX_DEF = 255;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb16_state_t;

endpackage

// File: rtl/rr_pick16.sv
// Rotate-priority encoder: first set req bit scanning ptr, ptr+1, ... wrapping.
// Ports: req[15:0], ptr[3:0] in; any (req nonzero), idx[3:0] (winner) out.
module rr_pick16
    import arb16_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] off;

    // rot[0] is req[ptr]; the lowest set bit of rot is the offset from ptr.
    always_comb begin
        rot = N_REQ'({req, req} >> ptr);
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end
        any = |req;
        idx = ptr + off;
    end

endmodule

// File: rtl/arb16_sched.sv
// Round-robin scheduler driving the registered 4-bit select of a 16:1 mux.
// Ports: clk, rst_n (sync, active-low), req[15:0] in; gnt[15:0], sel[3:0],
// valid, timeout out. Macro ARB16_TIMEOUT_EN builds the hold-limit revoke.
module arb16_sched
    import arb16_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic             timeout
);

    arb16_state_t     state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             rel;

    rr_pick16 u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

`ifdef ARB16_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       to_q, to_d;
    logic       expire;

    assign expire = (cnt_q == HOLD_LAST);
    // Voluntary release and forced revoke share one release path.
    assign rel    = !req[sel_q] || expire;
`else
    logic unused_hold;

    assign unused_hold = ^8'(HOLD_MAX);
    assign rel         = !req[sel_q];
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
`ifdef ARB16_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    gnt_d   = N_REQ'(1) << pick_idx;
                    sel_d   = pick_idx;
                    valid_d = 1'b1;
`ifdef ARB16_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                if (rel) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = sel_q + SEL_W'(1);
`ifdef ARB16_TIMEOUT_EN
                    // Owner still asking means this is a forced revoke.
                    to_d    = req[sel_q];
`endif
                end
`ifdef ARB16_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
`ifdef ARB16_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
`ifdef ARB16_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = valid_q;
`ifdef ARB16_TIMEOUT_EN
    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_arb16_sched.sv
// Bench for arb16_sched: tenure-level reference model checked every cycle,
// directed scenarios pinned by literal expectations, then random traffic.
module tb_arb16_sched;

`ifdef ARB16_TIMEOUT_EN
    localparam int HM    = 4;
    localparam bit TO_ON = 1'b1;
`else
    localparam int HM    = 255;
    localparam bit TO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        valid;
    logic        timeout;

    arb16_sched #(.HOLD_MAX(HM)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .valid   (valid),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference: who owns the mux, for how many cycles, and who is next up.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_sel   = 0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_sel   = 0;
            m_to    = 1'b0;
            m_held  = 0;
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                for (int k = 0; k < 16; k++) begin
                    if (req[(m_ptr + k) % 16]) begin
                        m_owner = (m_ptr + k) % 16;
                        m_sel   = m_owner;
                        m_held  = 1;
                        break;
                    end
                end
            end else if (!req[m_owner]) begin
                m_ptr   = (m_owner + 1) % 16;
                m_owner = -1;
            end else if (TO_ON && m_held == HM) begin
                m_ptr   = (m_owner + 1) % 16;
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_held++;
            end
        end
    end

    logic [15:0] exp_gnt;

    always @(negedge clk) begin
        exp_gnt = (m_owner < 0) ? 16'h0 : (16'h1 << m_owner);
        vectors++;
        if (gnt !== exp_gnt || sel !== 4'(m_sel) ||
            valid !== (m_owner >= 0) || timeout !== m_to) begin
            miscompares++;
            $display("FAIL model t=%0t gnt=%h want %h sel=%0d want %0d valid=%b want %b timeout=%b want %b",
                     $time, gnt, exp_gnt, sel, m_sel, valid, (m_owner >= 0),
                     timeout, m_to);
        end
    end

    task automatic lit(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int   glog[$];
    logic pv = 1'b0;

    task automatic tick();
        @(negedge clk);
        if (valid === 1'b1 && !pv) glog.push_back(int'(sel));
        pv = (valid === 1'b1);
    endtask

    // Each owner drops its request for its one granted cycle only.
    task automatic drop_run(input logic [15:0] mask, input int want);
        glog.delete();
        for (int c = 0; c < 200 && glog.size() < want; c++) begin
            req = (m_owner >= 0) ? (mask & ~(16'h1 << m_owner)) : mask;
            tick();
        end
    endtask

    int rr_exp[17];
    int pr_exp[3];

    initial begin
        for (int k = 0; k < 16; k++) rr_exp[k] = k;
        rr_exp[16] = 0;
        pr_exp[0] = 15;
        pr_exp[1] = 0;
        pr_exp[2] = 1;

        // Reset with everyone requesting.
        rst_n = 1'b0;
        req   = 16'hFFFF;
        repeat (3) begin
            tick();
            lit("rst_gnt", gnt, 16'h0);
            lit("rst_sel", 16'(sel), 16'h0);
            lit("rst_valid", 16'(valid), 16'h0);
        end
        rst_n = 1'b1;
        tick();
        lit("first_gnt", gnt, 16'h0001);
        lit("first_valid", 16'(valid), 16'h1);
        req = 16'h0;
        tick();
        tick();

        // Single requester 5 for five cycles.
        req = 16'h0020;
        for (int c = 1; c <= 5; c++) begin
            tick();
            lit("single_gnt", gnt, 16'h0020);
            lit("single_sel", 16'(sel), 16'h5);
        end
        req = 16'h0;
        tick();
        lit("single_clear", gnt, 16'h0);
        lit("single_clear_v", 16'(valid), 16'h0);
        // ptr is now 6, so 6 beats 0.
        req = 16'h0041;
        tick();
        lit("ptr_after_5", 16'(sel), 16'h6);
        req = 16'h0;
        tick();
        tick();

        // Full round robin from ptr 0 with wrap.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drop_run(16'hFFFF, 17);
        lit("rr_count", 16'(glog.size()), 16'd17);
        for (int k = 0; k < 17 && k < glog.size(); k++)
            lit("rr_order", 16'(glog[k]), 16'(rr_exp[k]));
        req = 16'h0;
        tick();
        tick();

        // Park ptr at 14, then 15 and 0,1 across the wrap.
        req = 16'h2000;
        tick();
        lit("park13", 16'(sel), 16'd13);
        req = 16'h0;
        tick();
        drop_run(16'h8003, 3);
        lit("prio_count", 16'(glog.size()), 16'd3);
        for (int k = 0; k < 3 && k < glog.size(); k++)
            lit("prio_order", 16'(glog[k]), 16'(pr_exp[k]));
        req = 16'h0;
        tick();
        tick();

        // Reset while requester 9 owns the mux.
        req = 16'h0200;
        tick();
        lit("mid_gnt9", gnt, 16'h0200);
        rst_n = 1'b0;
        tick();
        lit("mid_rst_gnt", gnt, 16'h0);
        lit("mid_rst_valid", 16'(valid), 16'h0);
        rst_n = 1'b1;
        req   = 16'h0600;
        tick();
        lit("mid_rearb", 16'(sel), 16'd9);
        req = 16'h0;
        tick();
        tick();

        // Requester 3 hogs while 4 waits (ptr is 10 here).
        req = 16'h0018;
`ifdef ARB16_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            tick();
            lit("hog_gnt", gnt, 16'h0008);
            lit("hog_to", 16'(timeout), 16'h0);
        end
        tick();
        lit("revoke_gnt", gnt, 16'h0);
        lit("revoke_to", 16'(timeout), 16'h1);
        tick();
        lit("next_gnt", gnt, 16'h0010);
        lit("next_to", 16'(timeout), 16'h0);
`else
        repeat (300) tick();
        lit("hog_gnt", gnt, 16'h0008);
        lit("hog_to", 16'(timeout), 16'h0);
`endif
        req = 16'h0;
        tick();
        tick();

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst_n = ($urandom_range(0, 199) != 0);
            req   = req ^ 16'($urandom & $urandom & $urandom);
        end
        rst_n = 1'b1;
        req   = 16'h0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
